one_byte_uart_rx: RTL and testbench
===================================

# one_byte_uart_rx

UART receiver for 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed baud rate derived from the system clock. It is the receive-side counterpart of the team's one-byte UART transmitter. It sits between the board RX pin and user logic, and delivers each received byte with a one-cycle valid strobe plus a framing-error flag. Bit timing is re-aligned to the start-bit falling edge of every frame, so no free-running baud tick is used.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- BAUD_CNT, CLK_FREQ/BAUD_RATE (434), clock cycles per bit. Simulation overrides this to 8.
- HALF_CNT, BAUD_CNT/2 (217), cycles from start-bit entry to the start-bit mid-sample.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- rx_in, input, 1, asynchronous serial line; idles high.
- rx_data, output, 8, last correctly framed byte. Reset 8'h00. Holds its value until the next good frame.
- rx_valid, output, 1, one-cycle pulse when rx_data is updated. Reset 0.
- rx_frame_err, output, 1, one-cycle pulse when the stop bit is sampled low. Reset 0.
- rx_busy, output, 1, high in every state except IDLE. Reset 0.

## Operation
- Synchronizer: rx_in passes through a 2-FF synchronizer (rx_s1 → rx_s2), then one more register (rx_s3) for edge detection. All three reset to 1.
- Falling-edge detect: rx_s3 == 1 and rx_s2 == 0.
- Internal registers: bit counter `cnt` (16 bits, any width that holds BAUD_CNT-1), bit index `bit_idx` (3 bits), shift register `shreg` (8 bits).
- FSM states: IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - cnt = 0, bit_idx = 0.
  - On falling edge → START.
- START:
  - cnt increments every cycle.
  - At cnt == HALF_CNT-1, sample rx_s2 and clear cnt.
  - rx_s2 == 0 → DATA. rx_s2 == 1 → IDLE (glitch rejected; no output pulse).
- DATA:
  - cnt increments every cycle.
  - At cnt == BAUD_CNT-1: cnt ← 0, shreg ← {rx_s2, shreg[7:1]} (LSB arrives first), bit_idx ← bit_idx + 1.
  - After the sample with bit_idx == 7 → STOP.
- STOP:
  - At cnt == BAUD_CNT-1, sample rx_s2, then go to IDLE.
  - Sample 1: rx_data ← shreg and rx_valid = 1 for one cycle.
  - Sample 0: rx_frame_err = 1 for one cycle; rx_data unchanged.
- A line held low after a frame error (break condition) does not retrigger the receiver. A new frame needs a high-to-low transition.
- rx_valid and rx_frame_err are mutually exclusive and are never high in consecutive cycles.

## Timing
- Let edge k be the clock edge at which the FSM enters START. k is the 3rd rising edge after rx_in falls, counting the first edge that captures the low level.
- Start-bit sample: edge k+HALF_CNT.
- Data bit i (i = 0..7) sample: edge k+HALF_CNT+(i+1)·BAUD_CNT.
- Stop-bit sample: edge k+HALF_CNT+9·BAUD_CNT.
  - rx_valid / rx_frame_err / rx_data are visible after this edge; at defaults that is k+4123.
  - The FSM is back in IDLE after the same edge.
- Back-to-back frames: the next start edge can be accepted in the cycle after the return to IDLE. The stop bit's second half remains as margin.
- Reset mid-frame:
  - All state and outputs return to reset values immediately.
  - After release, the remainder of the interrupted frame is not delivered as a byte. Any later falling edge inside that frame is treated as a new start bit and may produce a frame error; this is accepted.
- Baud tolerance: sampling at mid-bit gives about ±4% total clock mismatch margin over 10 bits.

## Test plan
All scenarios use BAUD_CNT=8, HALF_CNT=4 unless stated.
- Single frame, byte 0xA5, ideal timing → one rx_valid pulse, rx_data=8'hA5, no rx_frame_err, rx_busy low afterwards. Pulse edge matches the Timing formula exactly.
- Back-to-back frames 0x00 then 0xFF with no idle gap between stop and start → two rx_valid pulses exactly 10·BAUD_CNT cycles apart, with rx_data 8'h00 then 8'hFF.
- Glitch: rx_in low for 2 cycles, then high → FSM returns to IDLE at the start sample. No rx_valid, no rx_frame_err, rx_data unchanged.
- Framing error: frame carrying 0x3C with stop bit driven 0, line then held low 30 cycles → one rx_frame_err pulse, rx_data keeps the prior 8'hA5, no further activity until the line goes high and falls again.
- Reset mid-frame: assert rst_n low during data bit 3 → all outputs return to reset values immediately. The next clean frame 0x5A then yields rx_data=8'h5A.
- Loopback with the team transmitter (defaults 434/217, random 16 bytes) → every transmitted byte is received in order with zero framing errors.

Source files
------------

// File: rtl/one_byte_uart_rx_if.sv
// Receive-side bundle between the UART RX pin, the receiver and user logic.
// The slave modport is the receiver; the master modport drives the line and consumes bytes.
interface one_byte_uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  rx_frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx_in,
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output rx_busy
  );
endinterface

// File: rtl/one_byte_uart_rx.sv
// 8N1 UART receiver; bit timing restarts on every start-bit falling edge.
// Delivers each good byte with a one-cycle valid strobe, bad stop bits with a frame-error strobe.
//
// state | meaning
// IDLE  | line idle, waiting for a high-to-low transition
// START | counting to the start-bit middle, rejecting glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit, then reporting byte or framing error
module one_byte_uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int BAUD_CNT  = CLK_FREQ / BAUD_RATE,
  parameter int HALF_CNT  = BAUD_CNT / 2
) (
  input logic                   clk,
  input logic                   rst_n,
  one_byte_uart_rx_if.slave     bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);

  logic [1:0]  state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        fall;

  // A held-low line never produces a fall, so a break does not retrigger.
  assign fall = rx_s3 & ~rx_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_s3        <= 1'b1;
      state        <= IDLE;
      cnt          <= 16'd0;
      bit_idx      <= 3'd0;
      shreg        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= bus.rx_in;
      rx_s2        <= rx_s1;
      rx_s3        <= rx_s2;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 16'd0;
          bit_idx <= 3'd0;
          if (fall) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= 16'd0;
            state <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= 16'd0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt   <= 16'd0;
            state <= IDLE;
            if (rx_s2) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data      = rx_data;
  assign bus.rx_valid     = rx_valid;
  assign bus.rx_frame_err = rx_frame_err;
  assign bus.rx_busy      = (state != IDLE);

endmodule

// File: tb/tb_one_byte_uart_rx.sv
// Bench for one_byte_uart_rx: directed and random 8N1 frames against a frame-level model,
// plus a default-rate instance fed by a serial transmitter model.
module tb_one_byte_uart_rx;
  localparam int BAUD = 8;
  localparam int HALF = 4;
  localparam int BAUD_DEF = 50000000 / 115200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  one_byte_uart_rx_if rif ();
  one_byte_uart_rx_if rif_d ();

  one_byte_uart_rx #(.BAUD_CNT(BAUD), .HALF_CNT(HALF)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(rif.slave)
  );

  one_byte_uart_rx u_dut_def (
    .clk(clk), .rst_n(rst_n), .bus(rif_d.slave)
  );

  // observed strobes
  int         ev_cyc[$];
  logic [1:0] ev_kind[$];
  logic [7:0] ev_data[$];
  // expected strobes from the frame model
  int         exp_cyc[$];
  logic [1:0] exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] last_good = 8'h00;

  logic [7:0] def_rx[$];
  logic [7:0] def_tx[$];
  int         def_ferr = 0;

  always @(negedge clk) begin
    if (rif.rx_valid || rif.rx_frame_err) begin
      ev_cyc.push_back(cyc);
      ev_kind.push_back({rif.rx_valid, rif.rx_frame_err});
      ev_data.push_back(rif.rx_data);
    end
    if (rif_d.rx_valid) def_rx.push_back(rif_d.rx_data);
    if (rif_d.rx_frame_err) def_ferr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A frame's outcome depends only on its byte and stop bit; the strobe lands on the
  // stop-bit mid-sample, 3 sync edges + half a bit + 9 bits after the fall.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rif.rx_in = bits[i];
      if (i == 0) begin
        exp_cyc.push_back(cyc + 3 + HALF + 9 * BAUD);
        exp_kind.push_back(stop ? 2'b10 : 2'b01);
        exp_data.push_back(stop ? b : last_good);
        if (stop) last_good = b;
      end
      wait_cyc(BAUD);
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, ev_cyc.size(), exp_cyc.size());
    for (int i = 0; i < ev_cyc.size() && i < exp_cyc.size(); i++) begin
      check({tag, "_cyc"}, ev_cyc[i], exp_cyc[i]);
      check({tag, "_kind"}, 32'(ev_kind[i]), 32'(exp_kind[i]));
      check({tag, "_data"}, 32'(ev_data[i]), 32'(exp_data[i]));
    end
    ev_cyc.delete(); ev_kind.delete(); ev_data.delete();
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete();
  endtask

  task automatic send_def(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rif_d.rx_in = bits[i];
      wait_cyc(BAUD_DEF);
    end
  endtask

  initial begin
    rif.rx_in   = 1'b1;
    rif_d.rx_in = 1'b1;
    rst_n       = 1'b0;
    wait_cyc(3);
    check("rst_data", 32'(rif.rx_data), 32'h00);
    check("rst_valid", 32'(rif.rx_valid), 0);
    check("rst_ferr", 32'(rif.rx_frame_err), 0);
    check("rst_busy", 32'(rif.rx_busy), 0);
    rst_n = 1'b1;
    wait_cyc(5);

    send_frame(8'hA5, 1'b1);
    wait_cyc(4);
    compare_events("single_a5");
    check("single_busy", 32'(rif.rx_busy), 0);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(4);
    if (ev_cyc.size() == 2) check("b2b_spacing", ev_cyc[1] - ev_cyc[0], 10 * BAUD);
    else check("b2b_pulses", ev_cyc.size(), 2);
    compare_events("b2b");

    rif.rx_in = 1'b0;
    wait_cyc(2);
    rif.rx_in = 1'b1;
    wait_cyc(3);
    check("glitch_busy_mid", 32'(rif.rx_busy), 1);
    wait_cyc(10);
    check("glitch_busy_end", 32'(rif.rx_busy), 0);
    check("glitch_data", 32'(rif.rx_data), 32'hFF);
    compare_events("glitch");

    send_frame(8'hA5, 1'b1);
    wait_cyc(4);
    compare_events("pre_ferr");
    send_frame(8'h3C, 1'b0);
    wait_cyc(30);
    check("break_busy", 32'(rif.rx_busy), 0);
    check("break_data", 32'(rif.rx_data), 32'hA5);
    compare_events("ferr");
    rif.rx_in = 1'b1;
    wait_cyc(6);

    // abort a 0x5A frame halfway through data bit 3
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'h5A, 1'b0};
      for (int i = 0; i < 4; i++) begin
        rif.rx_in = bits[i];
        wait_cyc(BAUD);
      end
      rif.rx_in = bits[4];
      wait_cyc(BAUD / 2);
      check("mid_busy", 32'(rif.rx_busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_data", 32'(rif.rx_data), 32'h00);
      check("mid_rst_busy", 32'(rif.rx_busy), 0);
      check("mid_rst_valid", 32'(rif.rx_valid), 0);
      check("mid_rst_ferr", 32'(rif.rx_frame_err), 0);
      rif.rx_in = 1'b1;
      last_good = 8'h00;
      wait_cyc(4);
      rst_n = 1'b1;
      wait_cyc(6);
    end
    send_frame(8'h5A, 1'b1);
    wait_cyc(4);
    compare_events("after_rst");
    check("after_rst_data", 32'(rif.rx_data), 32'h5A);

    for (int f = 0; f < 20; f++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      rif.rx_in = 1'b1;
      wait_cyc($urandom_range(1, 20));
    end
    compare_events("random");

    for (int f = 0; f < 16; f++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      def_tx.push_back(b);
      send_def(b);
    end
    wait_cyc(20);
    check("loop_count", def_rx.size(), 16);
    for (int i = 0; i < def_rx.size() && i < def_tx.size(); i++)
      check("loop_byte", 32'(def_rx[i]), 32'(def_tx[i]));
    check("loop_ferr", def_ferr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
